// File: rtl/ext_bus_responder_if.sv
// 8051 external-bus pins seen by the responder: strobes, address/data buses and read-back drive.
// The MCU side is the master; the responder is the slave.
interface ext_bus_responder_if;
  logic       ALE;
  logic       RD_n;
  logic       WR_n;
  logic [7:0] P0_in;
  logic [7:0] P2_in;
  logic [7:0] P0_out;
  logic       P0_oe;

  modport master (
    output ALE, RD_n, WR_n, P0_in, P2_in,
    input  P0_out, P0_oe
  );

  modport slave (
    input  ALE, RD_n, WR_n, P0_in, P2_in,
    output P0_out, P0_oe
  );
endinterface

// File: rtl/ext_bus_responder.sv
// 8051 external-data-memory responder backed by a 256x8 RAM with a local host port.
// Bus pins are sampled through a 2-flop synchronizer; strobe edges are taken against a third stage.
module ext_bus_responder #(
  parameter logic [7:0] BASE_HI       = 8'hF0,
  parameter bit         HOLD_ON_ABORT = 1'b0
) (
  input  logic                      CLK,
  input  logic                      reset,
  ext_bus_responder_if.slave        bus,
  input  logic [7:0]                hst_addr,
  input  logic                      hst_we,
  input  logic [7:0]                hst_wdata,
  output logic [7:0]                hst_rdata,
  output logic [15:0]               acc_cnt,
  output logic                      bus_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StRead, StWrite} state_e;

  // {ALE, RD_n, WR_n, P0, P2}; idle levels loaded on reset
  localparam logic [18:0] SyncIdle = {1'b0, 1'b1, 1'b1, 16'h0000};

  logic [18:0] sync1_q, sync2_q;
  logic [2:0]  strb3_q;
  logic        ale_s, rd_n_s, wr_n_s;
  logic [7:0]  p0_s, p2_s;
  logic        ale_fall, rd_fall, rd_rise, wr_fall, wr_rise, both_low;

  state_e      state_q;
  logic [7:0]  addr_lo_q, wdata_q, p0_out_q, bus_rdata_q, hst_rdata_q;
  logic        sel_q, p0_oe_q, bus_err_q, bus_we;
  logic [15:0] acc_cnt_q;
  logic [7:0]  mem_q [256];

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q <= SyncIdle;
      sync2_q <= SyncIdle;
      strb3_q <= SyncIdle[18:16];
    end else begin
      sync1_q <= {bus.ALE, bus.RD_n, bus.WR_n, bus.P0_in, bus.P2_in};
      sync2_q <= sync1_q;
      strb3_q <= sync2_q[18:16];
    end
  end

  assign ale_s    = sync2_q[18];
  assign rd_n_s   = sync2_q[17];
  assign wr_n_s   = sync2_q[16];
  assign p0_s     = sync2_q[15:8];
  assign p2_s     = sync2_q[7:0];
  assign ale_fall = strb3_q[2] & ~ale_s;
  assign rd_fall  = strb3_q[1] & ~rd_n_s;
  assign rd_rise  = ~strb3_q[1] & rd_n_s;
  assign wr_fall  = strb3_q[0] & ~wr_n_s;
  assign wr_rise  = ~strb3_q[0] & wr_n_s;
  assign both_low = ~rd_n_s & ~wr_n_s;

  // A new ALE aborts an in-flight write before it commits
  assign bus_we = (state_q == StWrite) && wr_rise && !both_low && !ale_fall;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= StIdle;
      p0_oe_q   <= 1'b0;
      p0_out_q  <= 8'h00;
      acc_cnt_q <= 16'h0000;
      bus_err_q <= 1'b0;
      addr_lo_q <= 8'h00;
      sel_q     <= 1'b0;
      wdata_q   <= 8'h00;
    end else if (both_low) begin
      bus_err_q <= 1'b1;
      p0_oe_q   <= 1'b0;
      state_q   <= StIdle;
    end else if (ale_fall) begin
      addr_lo_q <= p0_s;
      sel_q     <= (p2_s == BASE_HI);
      state_q   <= StAddr;
      if (!(HOLD_ON_ABORT && state_q == StRead)) p0_oe_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: p0_oe_q <= 1'b0;
        StAddr: begin
          // Only non-zero here when a held read drive survives a new ALE
          if (rd_rise) p0_oe_q <= 1'b0;
          if (sel_q && rd_fall) begin
            state_q <= StRead;
          end else if (sel_q && wr_fall) begin
            state_q <= StWrite;
            wdata_q <= p0_s;
          end else if (rd_rise || wr_rise) begin
            state_q <= StIdle;
          end
        end
        StRead: begin
          if (rd_rise) begin
            p0_oe_q   <= 1'b0;
            acc_cnt_q <= acc_cnt_q + 16'd1;
            state_q   <= StIdle;
          end else begin
            p0_oe_q  <= 1'b1;
            p0_out_q <= bus_rdata_q;
          end
        end
        StWrite: begin
          p0_oe_q <= 1'b0;
          if (wr_rise) begin
            acc_cnt_q <= acc_cnt_q + 16'd1;
            state_q   <= StIdle;
          end else if (!wr_n_s) begin
            wdata_q <= p0_s;
          end
        end
      endcase
    end
  end

  // Bus write is applied last so it wins a same-address collision with the host
  always_ff @(posedge CLK) begin
    if (hst_we) mem_q[hst_addr] <= hst_wdata;
    if (bus_we) mem_q[addr_lo_q] <= wdata_q;
    bus_rdata_q <= mem_q[addr_lo_q];
  end

  always_ff @(posedge CLK) begin
    if (reset) hst_rdata_q <= 8'h00;
    else       hst_rdata_q <= mem_q[hst_addr];
  end

  assign bus.P0_out = p0_out_q;
  assign bus.P0_oe  = p0_oe_q;
  assign hst_rdata  = hst_rdata_q;
  assign acc_cnt    = acc_cnt_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Randomized scoreboard bench for ext_bus_responder: a transaction-level RAM/counter model
// queues expected read data; a monitor pops and compares whenever the DUT presents data.
module tb_ext_bus_responder;
  localparam logic [7:0] BaseHi = 8'hF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hst_addr, hst_wdata, hst_rdata;
  logic        hst_we;
  logic [15:0] acc_cnt;
  logic        bus_err;

  always #5 clk = ~clk;

  ext_bus_responder_if bus_if ();

  ext_bus_responder #(
    .BASE_HI       (BaseHi),
    .HOLD_ON_ABORT (1'b0)
  ) dut (
    .CLK       (clk),
    .reset     (rst),
    .bus       (bus_if),
    .hst_addr  (hst_addr),
    .hst_we    (hst_we),
    .hst_wdata (hst_wdata),
    .hst_rdata (hst_rdata),
    .acc_cnt   (acc_cnt),
    .bus_err   (bus_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [256];
  int unsigned exp_cnt;
  logic [7:0]  bus_q [$];
  logic [7:0]  hst_q [$];
  bit          hst_chk = 1'b0;
  bit          prev_oe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: P0_oe rising presents bus read data; hst_chk marks a host read result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.P0_oe && !prev_oe) begin
        if (bus_q.size() == 0) check("unexpected_P0_oe", {31'd0, bus_if.P0_oe}, 32'd0);
        else                   check("bus_rdata", {24'd0, bus_if.P0_out}, {24'd0, bus_q.pop_front()});
      end
      prev_oe = bus_if.P0_oe;
      if (hst_chk && hst_q.size() != 0)
        check("hst_rdata", {24'd0, hst_rdata}, {24'd0, hst_q.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion before 1 ms");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_addr(input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    bus_if.P0_in = lo;
    bus_if.P2_in = hi;
    bus_if.ALE   = 1'b1;
    cycles(3);
    bus_if.ALE   = 1'b0;
    cycles(4);
  endtask

  task automatic bus_read(input logic [7:0] lo, input logic [7:0] hi, input int low_len);
    bus_addr(lo, hi);
    if (hi == BaseHi) begin
      bus_q.push_back(ref_mem[lo]);
      exp_cnt++;
    end
    bus_if.RD_n = 1'b0;
    cycles(low_len);
    bus_if.RD_n = 1'b1;
    cycles(4);
    check("acc_cnt_after_read", {16'd0, acc_cnt}, exp_cnt);
  endtask

  task automatic bus_write(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] d,
                           input int low_len);
    bus_addr(lo, hi);
    bus_if.P0_in = d;
    bus_if.WR_n  = 1'b0;
    cycles(low_len);
    bus_if.WR_n  = 1'b1;
    cycles(4);
    if (hi == BaseHi) begin
      ref_mem[lo] = d;
      exp_cnt++;
    end
    check("acc_cnt_after_write", {16'd0, acc_cnt}, exp_cnt);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    hst_addr  = a;
    hst_wdata = d;
    hst_we    = 1'b1;
    @(negedge clk);
    hst_we    = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_read(input logic [7:0] a);
    @(negedge clk);
    hst_addr = a;
    hst_q.push_back(ref_mem[a]);
    hst_chk  = 1'b1;
    @(negedge clk);
    hst_chk  = 1'b0;
  endtask

  initial begin
    logic [7:0] lo, hi, d;
    int         op;

    rst          = 1'b1;
    bus_if.ALE   = 1'b0;
    bus_if.RD_n  = 1'b1;
    bus_if.WR_n  = 1'b1;
    bus_if.P0_in = 8'h00;
    bus_if.P2_in = 8'h00;
    hst_addr     = 8'h00;
    hst_wdata    = 8'h00;
    hst_we       = 1'b0;
    exp_cnt      = 0;
    cycles(3);
    check("rst_P0_oe", {31'd0, bus_if.P0_oe}, 32'd0);
    check("rst_P0_out", {24'd0, bus_if.P0_out}, 32'd0);
    check("rst_hst_rdata", {24'd0, hst_rdata}, 32'd0);
    check("rst_acc_cnt", {16'd0, acc_cnt}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;

    // Seed the model with known RAM contents for the addresses used below
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) host_write(8'(i), 8'(i * 7 + 3));

    // Bus write then timed bus read of the same byte
    bus_write(8'h12, BaseHi, 8'hA5, 6);
    host_read(8'h12);

    bus_addr(8'h12, BaseHi);
    bus_q.push_back(ref_mem[8'h12]);
    exp_cnt++;
    bus_if.RD_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 check("rd_oe_early1", {31'd0, bus_if.P0_oe}, 32'd0);
    @(posedge clk); #1 check("rd_oe_early2", {31'd0, bus_if.P0_oe}, 32'd0);
    @(posedge clk); #1 check("rd_oe_on", {31'd0, bus_if.P0_oe}, 32'd1);
    check("rd_P0_out", {24'd0, bus_if.P0_out}, 32'hA5);
    cycles(3);
    bus_if.RD_n = 1'b1;
    @(posedge clk); #1 check("rd_oe_hold1", {31'd0, bus_if.P0_oe}, 32'd1);
    @(posedge clk); #1 check("rd_oe_hold2", {31'd0, bus_if.P0_oe}, 32'd1);
    @(posedge clk); #1 check("rd_oe_off", {31'd0, bus_if.P0_oe}, 32'd0);
    check("acc_cnt_two", {16'd0, acc_cnt}, 32'd2);
    cycles(2);

    // Unselected page, then a strobe with no preceding ALE
    bus_read(8'h55, 8'h00, 6);
    bus_write(8'h20, 8'h01, 8'hEE, 5);
    host_read(8'h20);
    bus_if.RD_n = 1'b0;
    cycles(6);
    bus_if.RD_n = 1'b1;
    cycles(4);
    check("acc_cnt_idle_strobe", {16'd0, acc_cnt}, exp_cnt);

    // Same-cycle bus and host write to one address: bus data must win
    bus_addr(8'h30, BaseHi);
    bus_if.P0_in = 8'h11;
    bus_if.WR_n  = 1'b0;
    cycles(5);
    bus_if.WR_n  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hst_addr  = 8'h30;
    hst_wdata = 8'h22;
    hst_we    = 1'b1;
    @(negedge clk);
    hst_we    = 1'b0;
    ref_mem[8'h30] = 8'h11;
    exp_cnt++;
    cycles(3);
    host_read(8'h30);
    check("acc_cnt_collide", {16'd0, acc_cnt}, exp_cnt);

    // Randomized mix of bus and host traffic over a small address window
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      lo = 8'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      hi = BaseHi;
      if ($urandom_range(0, 3) == 0) begin
        hi = 8'($urandom_range(0, 255));
        if (hi == BaseHi) hi = 8'h00;
      end
      case (op)
        0:       bus_write(lo, hi, d, int'($urandom_range(3, 8)));
        1:       bus_read(lo, hi, int'($urandom_range(4, 8)));
        2:       host_write(lo, d);
        default: host_read(lo);
      endcase
    end

    // Both strobes low: sticky error, no write, no count
    bus_addr(8'h28, BaseHi);
    bus_if.P0_in = 8'h77;
    bus_if.RD_n  = 1'b0;
    bus_if.WR_n  = 1'b0;
    cycles(6);
    bus_if.RD_n  = 1'b1;
    bus_if.WR_n  = 1'b1;
    cycles(4);
    check("bus_err_set", {31'd0, bus_err}, 32'd1);
    check("acc_cnt_err", {16'd0, acc_cnt}, exp_cnt);
    host_read(8'h28);
    bus_read(8'h28, BaseHi, 5);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a read: drive drops, counters clear, RAM survives
    bus_addr(8'h12, BaseHi);
    bus_q.push_back(ref_mem[8'h12]);
    bus_if.RD_n = 1'b0;
    cycles(5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_P0_oe", {31'd0, bus_if.P0_oe}, 32'd0);
    check("rst_mid_acc_cnt", {16'd0, acc_cnt}, 32'd0);
    check("rst_mid_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    bus_if.RD_n = 1'b1;
    cycles(4);
    check("acc_cnt_post_rst", {16'd0, acc_cnt}, 32'd0);
    host_read(8'h12);
    host_read(8'h30);
    bus_write(8'h3C, BaseHi, 8'h5A, 4);
    bus_read(8'h3C, BaseHi, 5);

    cycles(4);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("hst_q_drained", 32'(hst_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
